ita_gelu_cfg: RTL and testbench
===============================

# ita_gelu_cfg

Configuration front end for the GELU activation datapath. It accepts GELU constants (`one`, `b`, `c`) and requantization parameters (`eps_mult`, `right_shift`, `add`) over a simple request/grant register bus into a shadow set. It promotes the shadow set atomically to an active set only at a datapath idle boundary. The active set drives the constant and requant inputs of the GELU lanes, so they never change mid-tile.

## Interface
Parameters:
- `CW`, default 16: GELU constant width (one/b/c), two's complement.
- `EW`, default 8: `eps_mult` width, unsigned.
- `SW`, default 8: `right_shift` width, unsigned.
- `AW`, default 8: `add` width, two's complement.

Ports:
- `clk_i`  in  1: clock. Single clock domain.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `cfg_req_i`  in  1: bus request.
- `cfg_gnt_o`  out  1: grant. Combinational, equals `cfg_req_i` (always accepted).
- `cfg_we_i`  in  1: 1 = write, 0 = read.
- `cfg_addr_i`  in  3: register index.
- `cfg_wdata_i`  in  32: write data.
- `cfg_rvalid_o`  out  1: response valid, one cycle after each granted request.
- `cfg_rdata_o`  out  32: read data, qualified by `cfg_rvalid_o`. 0 for writes.
- `commit_i`  in  1: hardware commit request pulse (alternative to the CTRL register).
- `busy_i`  in  1: GELU datapath is processing a tile. No promotion may occur while this is high.
- `one_o`, `b_o`, `c_o`  out  CW each: active constants.
- `eps_mult_o`  out  EW: active requant multiplier.
- `right_shift_o`  out  SW: active requant shift.
- `add_o`  out  AW: active requant offset.
- `cfg_valid_o`  out  1: at least one successful promotion since reset.
- `pending_o`  out  1: a commit is waiting for `busy_i` low.
- `err_o`  out  1: sticky flag for a rejected commit.

## Operation
Register map. Shadow registers are read/write; unmapped addresses read 0 and ignore writes.
- 0 ONE: `wdata[CW-1:0]`
- 1 B: `wdata[CW-1:0]`
- 2 C: `wdata[CW-1:0]`
- 3 RQS: `eps_mult=wdata[EW-1:0]`, `right_shift=wdata[8+SW-1:8]`, `add=wdata[16+AW-1:16]`
- 4 CTRL:
  - Write: bit0=1 requests a commit; bit1=1 clears `err_o`.
  - Read: `{29'b0, err, pending, cfg_valid}`.
- 5..7: unmapped.

Reads of registers 0–3 return the shadow value, sign-extended to 32 bits for signed fields. RQS reads back in its packed layout.

Commit flow:
- Pending FSM has two states, IDLE and PEND.
- A commit request (CTRL bit0 write, or `commit_i`) moves IDLE→PEND.
- In PEND, on the first rising edge where `busy_i`=0:
  - Validation passes if shadow `b` ≤ 0 (signed); `b` must be non-positive because the datapath clips `|x|` at `-b`.
  - On pass: shadow is copied to active, `cfg_valid_o`←1, FSM→IDLE.
  - On fail: active is unchanged, `err_o`←1, FSM→IDLE.
- A commit request in PEND is absorbed; the FSM stays in PEND.

Simultaneous events:
- Shadow write on the same edge as promotion: active takes the pre-write shadow value, and the write lands in shadow.
- New commit request on the same edge as promotion: FSM remains or returns to PEND, so a second promotion follows.
- A CTRL write with bit0 and bit1 both set: clears `err_o` first, then queues the commit.
- A set and clear of `err_o` on the same edge: set wins.

Reset clears all shadow and active registers, `cfg_valid_o`, `pending_o`, `err_o`, `cfg_rvalid_o` and `cfg_rdata_o` to 0, and puts the FSM in IDLE. Reset mid-PEND discards the pending commit.

## Timing
- Bus write takes effect in shadow at the granting edge. `cfg_rvalid_o` pulses on the next cycle.
- Bus read: data is sampled at the granting edge and presented with `cfg_rvalid_o` the next cycle. Back-to-back requests are allowed, one per cycle.
- `pending_o` rises the cycle after the commit request edge.
- Promotion with `busy_i` already low: active outputs change 1 cycle after the request edge, and `pending_o` stays low. So, request at edge N gives new outputs from edge N+1.
- Promotion with `busy_i` high: it happens at the first edge with `busy_i`=0; outputs and `pending_o`=0 are visible after that edge.
- Active outputs are registered, with no combinational path from the bus or from `busy_i`.

## Test plan
- **Reset:** hold `rst_ni`=0 mid-operation, then release → all outputs 0, CTRL reads 0.
- **Basic load:** write ONE=0x0100, B=0xFF00 (−256), C=0x0040, RQS=0x00_05_03_7F, then CTRL=1 with `busy_i`=0 → one cycle later `one_o`=0x0100, `b_o`=0xFF00, `c_o`=0x0040, `eps_mult_o`=0x7F, `right_shift_o`=3, `add_o`=5, `cfg_valid_o`=1.
- **Deferred commit:** `busy_i`=1, `commit_i` pulse → `pending_o`=1 and outputs unchanged for 20 cycles. Drop `busy_i` → outputs update after the next edge, then `pending_o`=0.
- **Write/promote collision:** with PEND active, write B=0xFE00 on the edge `busy_i` falls → `b_o`=old shadow value, and a B readback returns 0xFFFFFE00.
- **Rejected commit:** B=0x0010, commit → `err_o`=1 and active unchanged. CTRL write 0x2 → `err_o`=0.
- **Readback:** read addresses 0–7 back-to-back → `cfg_rvalid_o` high for 8 consecutive cycles, addresses 5–7 return 0.

Source files
------------

// File: rtl/ita_gelu_cfg.sv
// GELU configuration front end: shadow register set on a req/gnt bus,
// promoted atomically to the active set when the datapath is idle.
module ita_gelu_cfg #(
  parameter int unsigned CW = 16,
  parameter int unsigned EW = 8,
  parameter int unsigned SW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_req_i,
  output logic          cfg_gnt_o,
  input  logic          cfg_we_i,
  input  logic [2:0]    cfg_addr_i,
  input  logic [31:0]   cfg_wdata_i,
  output logic          cfg_rvalid_o,
  output logic [31:0]   cfg_rdata_o,
  input  logic          commit_i,
  input  logic          busy_i,
  output logic [CW-1:0] one_o,
  output logic [CW-1:0] b_o,
  output logic [CW-1:0] c_o,
  output logic [EW-1:0] eps_mult_o,
  output logic [SW-1:0] right_shift_o,
  output logic [AW-1:0] add_o,
  output logic          cfg_valid_o,
  output logic          pending_o,
  output logic          err_o
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t        state_q;
  logic [CW-1:0] sh_one, sh_b, sh_c;
  logic [EW-1:0] sh_eps;
  logic [SW-1:0] sh_rs;
  logic [AW-1:0] sh_add;

  logic          wr, rd, ctrl_wr;
  logic          commit_req, err_clr;
  logic          promote, b_ok, next_pend;
  logic [31:0]   rd_word;
  logic          unused_wdata;

  assign cfg_gnt_o    = cfg_req_i;
  assign wr           = cfg_req_i & cfg_we_i;
  assign rd           = cfg_req_i & ~cfg_we_i;
  assign ctrl_wr      = wr && (cfg_addr_i == 3'd4);
  assign commit_req   = commit_i | (ctrl_wr & cfg_wdata_i[0]);
  assign err_clr      = ctrl_wr & cfg_wdata_i[1];
  assign promote      = (state_q == PEND) & ~busy_i;
  assign b_ok         = sh_b[CW-1] | (sh_b == '0);
  assign next_pend    = commit_req | ((state_q == PEND) & busy_i);
  assign unused_wdata = ^cfg_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_one <= '0;
      sh_b   <= '0;
      sh_c   <= '0;
      sh_eps <= '0;
      sh_rs  <= '0;
      sh_add <= '0;
    end else if (wr) begin
      unique case (cfg_addr_i)
        3'd0: sh_one <= cfg_wdata_i[CW-1:0];
        3'd1: sh_b   <= cfg_wdata_i[CW-1:0];
        3'd2: sh_c   <= cfg_wdata_i[CW-1:0];
        3'd3: begin
          sh_eps <= cfg_wdata_i[EW-1:0];
          sh_rs  <= cfg_wdata_i[8 +: SW];
          sh_add <= cfg_wdata_i[16 +: AW];
        end
        default: ;
      endcase
    end
  end

  // Commit FSM; the error set outranks a same-edge clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pending_o     <= 1'b0;
      err_o         <= 1'b0;
      cfg_valid_o   <= 1'b0;
      one_o         <= '0;
      b_o           <= '0;
      c_o           <= '0;
      eps_mult_o    <= '0;
      right_shift_o <= '0;
      add_o         <= '0;
    end else begin
      state_q   <= next_pend ? PEND : IDLE;
      pending_o <= next_pend & busy_i;
      if (promote && b_ok) begin
        one_o         <= sh_one;
        b_o           <= sh_b;
        c_o           <= sh_c;
        eps_mult_o    <= sh_eps;
        right_shift_o <= sh_rs;
        add_o         <= sh_add;
        cfg_valid_o   <= 1'b1;
      end
      if (promote && !b_ok) err_o <= 1'b1;
      else if (err_clr)     err_o <= 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    unique case (cfg_addr_i)
      3'd0: rd_word = {{(32-CW){sh_one[CW-1]}}, sh_one};
      3'd1: rd_word = {{(32-CW){sh_b[CW-1]}}, sh_b};
      3'd2: rd_word = {{(32-CW){sh_c[CW-1]}}, sh_c};
      3'd3: begin
        rd_word[EW-1:0]   = sh_eps;
        rd_word[8 +: SW]  = sh_rs;
        rd_word[16 +: AW] = sh_add;
      end
      3'd4: rd_word = {29'b0, err_o, pending_o, cfg_valid_o};
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_rdata_o  <= rd ? rd_word : 32'h0;
    end
  end

endmodule

// File: tb/tb_ita_gelu_cfg.sv
// Directed bench for ita_gelu_cfg: bus load, commit timing,
// collisions, rejection and back-to-back readback.
module tb_ita_gelu_cfg;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_req_i = 1'b0;
  logic        cfg_gnt_o;
  logic        cfg_we_i = 1'b0;
  logic [2:0]  cfg_addr_i = 3'd0;
  logic [31:0] cfg_wdata_i = 32'h0;
  logic        cfg_rvalid_o;
  logic [31:0] cfg_rdata_o;
  logic        commit_i = 1'b0;
  logic        busy_i = 1'b0;
  logic [15:0] one_o, b_o, c_o;
  logic [7:0]  eps_mult_o, right_shift_o, add_o;
  logic        cfg_valid_o, pending_o, err_o;

  int checks = 0;
  int failures = 0;

  ita_gelu_cfg dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o),
    .commit_i(commit_i), .busy_i(busy_i),
    .one_o(one_o), .b_o(b_o), .c_o(c_o),
    .eps_mult_o(eps_mult_o), .right_shift_o(right_shift_o),
    .add_o(add_o), .cfg_valid_o(cfg_valid_o),
    .pending_o(pending_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_i);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1;
    cfg_addr_i = a; cfg_wdata_i = d;
    @(negedge clk_i);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk_i);
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = a;
    @(negedge clk_i);
    cfg_req_i = 1'b0;
    chk("rd_rvalid", {31'b0, cfg_rvalid_o}, 32'h1);
    d = cfg_rdata_o;
  endtask

  task automatic pulse_commit();
    @(negedge clk_i);
    commit_i = 1'b1;
    @(negedge clk_i);
    commit_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_one"}, {16'b0, one_o}, 32'h0);
    chk({tag, "_b"}, {16'b0, b_o}, 32'h0);
    chk({tag, "_c"}, {16'b0, c_o}, 32'h0);
    chk({tag, "_rqs"}, {8'b0, add_o, right_shift_o, eps_mult_o}, 32'h0);
    chk({tag, "_flags"}, {29'b0, err_o, pending_o, cfg_valid_o}, 32'h0);
    chk({tag, "_rsp"}, {31'b0, cfg_rvalid_o} | cfg_rdata_o, 32'h0);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  initial begin
    rd_vec_t tbl [8];
    logic [31:0] d;

    // Readback table for the shadow state reached before that test
    tbl[0] = '{3'd0, 32'h0000_0200};
    tbl[1] = '{3'd1, 32'h0000_0010};
    tbl[2] = '{3'd2, 32'h0000_0040};
    tbl[3] = '{3'd3, 32'h0005_037F};
    tbl[4] = '{3'd4, 32'h0000_0001};
    tbl[5] = '{3'd5, 32'h0};
    tbl[6] = '{3'd6, 32'h0};
    tbl[7] = '{3'd7, 32'h0};

    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    chk_all_zero("reset");
    bus_rd(3'd4, d);
    chk("reset_ctrl_rd", d, 32'h0);

    // Basic load with busy low: outputs one edge after request edge
    bus_wr(3'd0, 32'h0000_0100);
    bus_wr(3'd1, 32'h0000_FF00);
    bus_wr(3'd2, 32'h0000_0040);
    bus_wr(3'd3, 32'h0005_037F);
    chk("wr_rvalid", {31'b0, cfg_rvalid_o}, 32'h1);
    chk("wr_rdata", cfg_rdata_o, 32'h0);
    bus_wr(3'd4, 32'h1);
    chk("load_pend_low", {31'b0, pending_o}, 32'h0);
    chk("load_one_old", {16'b0, one_o}, 32'h0);
    @(negedge clk_i);
    chk("load_one", {16'b0, one_o}, 32'h0100);
    chk("load_b", {16'b0, b_o}, 32'hFF00);
    chk("load_c", {16'b0, c_o}, 32'h0040);
    chk("load_eps", {24'b0, eps_mult_o}, 32'h7F);
    chk("load_rs", {24'b0, right_shift_o}, 32'h3);
    chk("load_add", {24'b0, add_o}, 32'h5);
    chk("load_valid", {31'b0, cfg_valid_o}, 32'h1);
    chk("load_pend", {31'b0, pending_o}, 32'h0);
    bus_rd(3'd1, d);
    chk("b_sext", d, 32'hFFFF_FF00);

    // Deferred commit held off by busy
    bus_wr(3'd0, 32'h0000_0200);
    busy_i = 1'b1;
    pulse_commit();
    for (int i = 0; i < 20; i++) begin
      chk("defer_pend", {31'b0, pending_o}, 32'h1);
      chk("defer_one", {16'b0, one_o}, 32'h0100);
      @(negedge clk_i);
    end
    busy_i = 1'b0;
    chk("defer_one_pre", {16'b0, one_o}, 32'h0100);
    @(negedge clk_i);
    chk("defer_one_new", {16'b0, one_o}, 32'h0200);
    chk("defer_pend_clr", {31'b0, pending_o}, 32'h0);

    // Shadow write on the promoting edge: active gets old shadow
    busy_i = 1'b1;
    pulse_commit();
    repeat (3) @(negedge clk_i);
    chk("coll_pend", {31'b0, pending_o}, 32'h1);
    busy_i = 1'b0;
    cfg_req_i = 1'b1; cfg_we_i = 1'b1;
    cfg_addr_i = 3'd1; cfg_wdata_i = 32'h0000_FE00;
    @(negedge clk_i);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    chk("coll_b_active", {16'b0, b_o}, 32'hFF00);
    chk("coll_pend_clr", {31'b0, pending_o}, 32'h0);
    bus_rd(3'd1, d);
    chk("coll_b_shadow", d, 32'hFFFF_FE00);

    // Positive b is rejected and active stays put
    bus_wr(3'd1, 32'h0000_0010);
    bus_wr(3'd4, 32'h1);
    @(negedge clk_i);
    chk("rej_err", {31'b0, err_o}, 32'h1);
    chk("rej_b", {16'b0, b_o}, 32'hFF00);
    chk("rej_one", {16'b0, one_o}, 32'h0200);
    bus_rd(3'd4, d);
    chk("rej_ctrl", d, 32'h5);
    bus_wr(3'd4, 32'h2);
    chk("rej_err_clr", {31'b0, err_o}, 32'h0);

    // Back-to-back reads of every address
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk_i);
      if (i > 0) begin
        chk("bb_rvalid", {31'b0, cfg_rvalid_o}, 32'h1);
        chk($sformatf("bb_rdata%0d", i - 1), cfg_rdata_o, tbl[i-1].exp);
      end
      if (i < 8) begin
        cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = tbl[i].addr;
      end else begin
        cfg_req_i = 1'b0;
      end
    end
    @(negedge clk_i);
    chk("bb_rvalid_end", {31'b0, cfg_rvalid_o}, 32'h0);

    // Reset while a commit is pending discards it
    bus_wr(3'd1, 32'h0000_FF80);
    busy_i = 1'b1;
    pulse_commit();
    chk("rst_pre_pend", {31'b0, pending_o}, 32'h1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk_all_zero("midrst");
    rst_ni = 1'b1;
    busy_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_all_zero("postrst");
    bus_rd(3'd1, d);
    chk("postrst_b_shadow", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
